if_stage: RTL and testbench

Instruction fetch stage directly upstream of the main decoder (maindec) in the RISC-V core.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request port; responses are in order with variable latency.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Decode receives instr, pc, pc+4 and the 7-bit opcode field that drives maindec's op input.
- Handles PC redirects from branch/jump resolution, flushing the buffer and discarding in-flight responses.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/if_fifo.sv | 70 +++++++
 rtl/if_stage.sv | 168 ++++++++++++++++
 tb/tb_if_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types and constants for the fetch stage
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - small synchronous FIFO used for the fetch buffer and the pc tag queue
module if_fifo #(
    parameter type T     = riscv_pkg::fetch_entry_t,
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  T            pushData,
    input  logic        pop,
    input  logic        flush,
    output T            headData,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    T               mem [DEPTH];
    logic [AW-1:0]  rdPtr;
    logic [AW-1:0]  wrPtr;
    logic [AW:0]    countNext;
    logic           doPush;
    logic           doPop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign doPop    = pop && !empty;
    // A pop frees the slot the same cycle, so push-while-full is legal with a pop.
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    always_comb begin
        countNext = count;
        if (doPush && !doPop) begin
            countNext = count + (AW+1)'(1);
        end else if (doPop && !doPush) begin
            countNext = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= countNext;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !reset && !flush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            assert (!full || pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RISC-V instruction fetch stage feeding maindec
// Optional MISALIGN_TRAP_EN: misaligned redirect sets sticky misalign and halts fetch until reset.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pcplus4,
    output logic [6:0]      id_op,
    output logic            misalign
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    stateNext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirectTarget;
    logic [XLEN-1:0] tagHead;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discardNext;
    logic [CW-1:0]   fifoCount;
    logic [CW-1:0]   tagCount;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            tagFull;
    logic            tagEmpty;
    logic            reqFire;
    logic            rspKeep;
    logic            hsFire;
    logic            redirectTake;
    logic            badRedirect;
    fetch_entry_t    head;
    fetch_entry_t    pushEntry;

    // The tag queue holds one pc per in-flight request, so its occupancy is the outstanding count.
    assign imem_req_valid = !reset && (state == FETCH) &&
                            (({1'b0, tagCount} + {1'b0, fifoCount}) < (CW+1)'(BUF_DEPTH));
    assign imem_addr      = pc;
    assign reqFire        = imem_req_valid && imem_req_ready;
    assign hsFire         = id_valid && id_ready;
    assign redirectTake   = redirect && (state != HALT);
    assign redirectTarget = {redirect_pc[XLEN-1:2], 2'b00};
    assign rspKeep        = imem_rsp_valid && (discard == '0) && (state != HALT);
    assign pushEntry      = '{instr: imem_rsp_data, pc: tagHead};

    assign id_valid   = !fifoEmpty;
    assign id_instr   = head.instr;
    assign id_pc      = head.pc;
    assign id_pcplus4 = head.pc + XLEN'(4);
    assign id_op      = head.instr[6:0];

`ifdef MISALIGN_TRAP_EN
    logic misalignReg;

    assign badRedirect = (redirect_pc[1:0] != 2'b00);
    assign misalign    = misalignReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalignReg <= 1'b0;
        end else if (redirectTake && badRedirect) begin
            misalignReg <= 1'b1;
        end
    end
`else
    logic unusedRedirectLsbs;

    assign unusedRedirectLsbs = ^redirect_pc[1:0];
    assign badRedirect        = 1'b0;
    assign misalign           = 1'b0;
`endif

    // Requests accepted in the redirect cycle belong to the old stream, hence counted into discard.
    always_comb begin
        discardNext = discard;
        stateNext   = state;
        if (imem_rsp_valid && (discard != '0)) begin
            discardNext = discard - CW'(1);
        end
        if (redirectTake) begin
            discardNext = tagCount + CW'(reqFire) - CW'(imem_rsp_valid);
        end
        case (state)
            FETCH, DRAIN: begin
                if (redirectTake && badRedirect) begin
                    stateNext = HALT;
                end else if (discardNext != '0) begin
                    stateNext = DRAIN;
                end else begin
                    stateNext = FETCH;
                end
            end
            default: stateNext = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            discard <= '0;
            pc      <= RESET_PC;
        end else begin
            state   <= stateNext;
            discard <= discardNext;
            if (redirectTake) begin
                pc <= redirectTarget;
            end else if (reqFire) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    if_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (rspKeep),
        .pushData (pushEntry),
        .pop      (hsFire),
        .flush    (redirectTake || (redirect && badRedirect)),
        .headData (head),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    if_fifo #(
        .T     (logic [XLEN-1:0]),
        .DEPTH (BUF_DEPTH)
    ) u_tag (
        .clk      (clk),
        .reset    (reset),
        .push     (reqFire),
        .pushData (imem_addr),
        .pop      (imem_rsp_valid),
        .flush    (1'b0),
        .headData (tagHead),
        .count    (tagCount),
        .full     (tagFull),
        .empty    (tagEmpty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && tagEmpty));
            assert (!(reqFire && tagFull && !imem_rsp_valid));
            assert (!(rspKeep && !redirectTake && fifoFull && !hsFire));
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage
module tb_if_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;
    logic [6:0]  id_op;
    logic        misalign;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int latMin = 1;
    int latMax = 1;
    int readyPct = 100;
    logic [31:0] addrQ [$];
    int          dueQ [$];
    logic [31:0] reqLog [$];
    logic [6:0]  opTab [6] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_I, OP_JAL};

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pcplus4     (id_pcplus4),
        .id_op          (id_op),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents: opcode cycles through the six maindec classes by word index.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] h;
        int idx;
        h = a * 32'h9E37_79B1;
        idx = int'((a >> 2) % 32'd6);
        return {h[31:7], opTab[idx]};
    endfunction

    // In-order memory with per-request latency; acts just after each falling edge.
    always @(negedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        if (reset) begin
            addrQ.delete();
            dueQ.delete();
            imem_req_ready = 1'b0;
        end else begin
            if (addrQ.size() > 0 && dueQ[0] <= cyc + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = memWord(addrQ.pop_front());
                void'(dueQ.pop_front());
            end
            imem_req_ready = (int'($urandom_range(99)) < readyPct);
            if (imem_req_valid && imem_req_ready) begin
                addrQ.push_back(imem_addr);
                reqLog.push_back(imem_addr);
                dueQ.push_back(cyc + 1 + int'($urandom_range(latMax, latMin)));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [6:0]  wantOps [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111};
        logic [31:0] expPc = 32'h0;
        logic [31:0] want;
        int k = 0;
        int firstValid = -1;
        latMin = 1; latMax = 1; readyPct = 100;
        do_reset();
        reqLog.delete();
        id_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (id_valid && firstValid < 0) firstValid = c;
            if (id_valid && id_ready) begin
                want = memWord(expPc);
                if (k < 6) begin
                    total++; if (id_op !== wantOps[k]) begin bad++; $display("FAIL stream_op[%0d]: got %b want %b", k, id_op, wantOps[k]); end
                end
                total++; if (id_pc !== expPc) begin bad++; $display("FAIL stream_pc: got %h want %h", id_pc, expPc); end
                total++; if (id_pcplus4 !== expPc + 32'd4) begin bad++; $display("FAIL stream_pcplus4: got %h want %h", id_pcplus4, expPc + 32'd4); end
                total++; if (id_instr !== want) begin bad++; $display("FAIL stream_instr: got %h want %h", id_instr, want); end
                expPc += 32'd4;
                k++;
            end
        end
        total++; if (firstValid != 2) begin bad++; $display("FAIL stream_latency: got %0d want 2", firstValid); end
        total++; if (k < 6) begin bad++; $display("FAIL stream_count: got %0d want >=6", k); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (reqLog.size() <= i) begin bad++; $display("FAIL stream_addr[%0d]: got none want %h", i, 4 * i); end
            else if (reqLog[i] !== 32'(4 * i)) begin bad++; $display("FAIL stream_addr[%0d]: got %h want %h", i, reqLog[i], 4 * i); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expPc = 32'h0;
        int k = 0;
        latMin = 1; latMax = 1; readyPct = 100;
        do_reset();
        reqLog.delete();
        repeat (10) @(negedge clk);
        total++; if (reqLog.size() != 2) begin bad++; $display("FAIL bp_req_count: got %0d want 2", reqLog.size()); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL bp_id_valid: got %b want 1", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL bp_id_pc: got %h want 0", id_pc); end
        for (int c = 0; c < 20 && k < 3; c++) begin
            @(negedge clk);
            id_ready = 1'b1;
            if (id_valid) begin
                total++; if (id_pc !== expPc) begin bad++; $display("FAIL bp_release_pc: got %h want %h", id_pc, expPc); end
                expPc += 32'd4;
                k++;
            end
        end
        total++; if (k != 3) begin bad++; $display("FAIL bp_release_count: got %0d want 3", k); end
    endtask

    task automatic test_redirect_drain();
        int base;
        bit seen = 1'b0;
        latMin = 4; latMax = 4; readyPct = 100;
        do_reset();
        repeat (2) @(negedge clk);
        total++; if (addrQ.size() != 2) begin bad++; $display("FAIL drain_inflight: got %0d want 2", addrQ.size()); end
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        base = reqLog.size();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL drain_req_valid: got %b want 0", imem_req_valid); end
        id_ready = 1'b1;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (id_valid) begin
                seen = 1'b1;
                total++; if (id_pc !== 32'h100) begin bad++; $display("FAIL drain_first_pc: got %h want 100", id_pc); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL drain_timeout: got no id_valid want one"); end
        total++;
        if (reqLog.size() <= base) begin bad++; $display("FAIL drain_addr: got none want 100"); end
        else if (reqLog[base] !== 32'h100) begin bad++; $display("FAIL drain_addr: got %h want 100", reqLog[base]); end
    endtask

    task automatic test_redirect_handshake();
        logic [31:0] expPc = 32'h0;
        bit redirDone = 1'b0;
        int after = 0;
        latMin = 1; latMax = 1; readyPct = 100;
        do_reset();
        id_ready = 1'b1;
        for (int c = 0; c < 40 && after < 2; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            if (id_valid) begin
                total++; if (id_pc !== expPc) begin bad++; $display("FAIL rh_pc: got %h want %h", id_pc, expPc); end
                if (redirDone) after++;
                if (id_pc === 32'h8 && !redirDone) begin
                    redirect = 1'b1;
                    redirect_pc = 32'h40;
                    redirDone = 1'b1;
                    expPc = 32'h40;
                end else begin
                    expPc += 32'd4;
                end
            end
        end
        redirect = 1'b0;
        total++; if (after < 2) begin bad++; $display("FAIL rh_timeout: got %0d want 2 post-redirect transfers", after); end
    endtask

    task automatic test_wrap();
        logic [31:0] expPc = 32'hFFFF_FFFC;
        int base;
        int k = 0;
        latMin = 1; latMax = 1; readyPct = 100;
        do_reset();
        id_ready = 1'b1;
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        base = reqLog.size();
        for (int c = 0; c < 30 && k < 2; c++) begin
            if (id_valid) begin
                total++; if (id_pc !== expPc) begin bad++; $display("FAIL wrap_pc: got %h want %h", id_pc, expPc); end
                total++; if (id_pcplus4 !== expPc + 32'd4) begin bad++; $display("FAIL wrap_pcplus4: got %h want %h", id_pcplus4, expPc + 32'd4); end
                expPc += 32'd4;
                k++;
            end
            @(negedge clk);
        end
        total++; if (k != 2) begin bad++; $display("FAIL wrap_count: got %0d want 2", k); end
        total++;
        if (reqLog.size() < base + 2) begin bad++; $display("FAIL wrap_addr: got %0d requests want 2", reqLog.size() - base); end
        else if (reqLog[base] !== 32'hFFFF_FFFC || reqLog[base + 1] !== 32'h0) begin
            bad++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", reqLog[base], reqLog[base + 1]);
        end
    endtask

    task automatic test_random();
        logic [31:0] expPc = 32'h0;
        logic [31:0] want;
        logic [31:0] tgt;
        logic [31:0] lastAddr = '0;
        bit lastValid = 1'b0;
        bit lastRedir = 1'b0;
        int hs = 0;
        latMin = 1; latMax = 4; readyPct = 70;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (lastValid && !imem_req_ready && !lastRedir) begin
                total++; if (imem_addr !== lastAddr) begin bad++; $display("FAIL rnd_addr_stable: got %h want %h", imem_addr, lastAddr); end
            end
            total++; if (addrQ.size() > 2) begin bad++; $display("FAIL rnd_outstanding: got %0d want <=2", addrQ.size()); end
            lastValid = imem_req_valid;
            lastAddr = imem_addr;
            redirect = 1'b0;
            id_ready = ($urandom_range(3) != 0);
            if (id_valid && id_ready) begin
                want = memWord(expPc);
                total++; if (id_pc !== expPc) begin bad++; $display("FAIL rnd_pc: got %h want %h", id_pc, expPc); end
                total++; if (id_instr !== want) begin bad++; $display("FAIL rnd_instr: got %h want %h", id_instr, want); end
                total++; if (id_pcplus4 !== expPc + 32'd4) begin bad++; $display("FAIL rnd_pcplus4: got %h want %h", id_pcplus4, expPc + 32'd4); end
                total++; if (id_op !== want[6:0]) begin bad++; $display("FAIL rnd_op: got %b want %b", id_op, want[6:0]); end
                expPc += 32'd4;
                hs++;
            end
            if ($urandom_range(99) < 3) begin
                tgt = $urandom;
`ifdef MISALIGN_TRAP_EN
                tgt[1:0] = 2'b00;
`endif
                redirect = 1'b1;
                redirect_pc = tgt;
                expPc = {tgt[31:2], 2'b00};
            end
            lastRedir = redirect;
        end
        redirect = 1'b0;
        total++; if (hs < 200) begin bad++; $display("FAIL rnd_progress: got %0d transfers want >=200", hs); end
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rnd_misalign: got %b want 0", misalign); end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        bit seen = 1'b0;
        latMin = 1; latMax = 1; readyPct = 100;
        do_reset();
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        id_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b want 1", misalign); end
            total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req_valid: got %b want 0", imem_req_valid); end
            total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL mis_id_valid: got %b want 0", id_valid); end
        end
        do_reset();
        total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_reset: got %b want 0", misalign); end
        id_ready = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (id_valid) begin
                seen = 1'b1;
                total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL mis_restart_pc: got %h want 0", id_pc); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL mis_restart_timeout: got no id_valid want one"); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_handshake();
        test_wrap();
        test_random();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
